// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM port status and arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Status reported by the shared RAM port.
  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  // Memory arbiter FSM state.
  typedef enum logic [1:0] {
    IDLE,
    DATA,
    INSTR,
    FAULT
  } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog for the memory arbiter.
// Counts granted cycles that did not complete; expired is high once the count
// reaches TIMEOUT-1. The counter saturates there and never wraps.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   clear   : force the count to zero (held while no grant is active)
//   enable  : count this cycle (granted and RAM did not report ACCESS)
//   expired : count == TIMEOUT-1
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CntMax)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == CntMax);

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates one shared RAM port between instruction fetch and data access.
// Data has priority. Every grant costs one IDLE arbitration cycle and every
// completion or abort returns to IDLE, so a held request is never reissued.
// A grant that sees ERROR or exceeds TIMEOUT cycles locks into FAULT until RST.
//   CLK, RST                 : clock, synchronous active-high reset
//   iREN, iaddr              : fetch request / address
//   iload, iwait             : fetched word / fetch stall (low one cycle on completion)
//   dREN, dWEN, daddr, dstore: data request, address, write value
//   dload, dwait             : read value / data stall (low one cycle on completion)
//   ramREN, ramWEN, ramaddr, ramstore, ramload, ramstate : shared RAM port
//   err                      : sticky fault flag
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);

  arb_state_t state_q, state_d;
  logic       granted;
  logic       wd_enable;
  logic       expired;

  assign granted   = (state_q == DATA) || (state_q == INSTR);
  assign wd_enable = granted && (ramstate != ACCESS);

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (CLK),
    .rst    (RST),
    .clear  (!granted),
    .enable (wd_enable),
    .expired(expired)
  );

  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;

    unique case (state_q)
      IDLE: begin
        if (dREN || dWEN) begin
          state_d = DATA;
        end else if (iREN) begin
          state_d = INSTR;
        end
      end

      DATA: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;  // a write wins over a simultaneous read
        if (ramstate == ERROR) begin
          state_d = FAULT;
        end else if (!(dREN || dWEN)) begin
          state_d = IDLE;  // abort: no wait pulse
        end else if (ramstate == ACCESS) begin
          dwait   = 1'b0;
          dload   = ramload;
          state_d = IDLE;
        end else if (expired) begin
          state_d = FAULT;
        end
      end

      INSTR: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (ramstate == ERROR) begin
          state_d = FAULT;
        end else if (!iREN) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          iwait   = 1'b0;
          iload   = ramload;
          state_d = IDLE;
        end else if (expired) begin
          state_d = FAULT;
        end
      end

      FAULT: begin
        state_d = FAULT;  // only RST leaves FAULT
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FAULT is sticky until reset, so the flag follows the state directly.
  assign err = (state_q == FAULT);

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter (TIMEOUT=4). Inputs change on the falling
// edge; outputs are checked 1 time unit later, well away from the rising edge.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      RST;
  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      iwait;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dwait;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 CLK = ~CLK;

  memory_arbiter #(
    .TIMEOUT(4)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iload   (iload),
    .iwait   (iwait),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dload   (dload),
    .dwait   (dwait),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .err     (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; caller then drives inputs and settles.
  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // Reset state
    cyc(); cyc(); settle();
    check("rst_iwait", 32'(iwait), 32'd1);
    check("rst_dwait", 32'(dwait), 32'd1);
    check("rst_ramren", 32'(ramREN), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ramaddr", ramaddr, 32'h0);
    RST = 1'b0;

    // Fetch only
    cyc(); iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; settle();
    check("f_arb_ramren", 32'(ramREN), 32'd0);
    cyc(); settle();
    check("f_c1_ramren", 32'(ramREN), 32'd1);
    check("f_c1_ramaddr", ramaddr, 32'h40);
    check("f_c1_iwait", 32'(iwait), 32'd1);
    check("f_c1_iload", iload, 32'h0);
    cyc(); ramstate = ACCESS; ramload = 32'h3C010001; settle();
    check("f_c2_iwait", 32'(iwait), 32'd0);
    check("f_c2_iload", iload, 32'h3C010001);
    cyc(); iREN = 1'b0; ramstate = FREE; settle();
    check("f_idle_ramren", 32'(ramREN), 32'd0);
    check("f_idle_iwait", 32'(iwait), 32'd1);
    check("f_idle_iload", iload, 32'h0);

    // Contention, then fetch abort
    cyc(); dREN = 1'b1; iREN = 1'b1; daddr = 32'h80; iaddr = 32'h100; ramstate = BUSY;
    settle();
    check("c_arb_dwait", 32'(dwait), 32'd1);
    check("c_arb_ramren", 32'(ramREN), 32'd0);
    cyc(); settle();
    check("c_data_ramaddr", ramaddr, 32'h80);
    check("c_data_ramren", 32'(ramREN), 32'd1);
    ramstate = ACCESS; ramload = 32'h1234; settle();
    check("c_data_dwait", 32'(dwait), 32'd0);
    check("c_data_dload", dload, 32'h1234);
    check("c_data_iwait", 32'(iwait), 32'd1);
    cyc(); dREN = 1'b0; ramstate = BUSY; settle();
    check("c_turn_ramren", 32'(ramREN), 32'd0);
    check("c_turn_ramaddr", ramaddr, 32'h0);
    check("c_turn_dwait", 32'(dwait), 32'd1);
    cyc(); settle();
    check("c_instr_ramaddr", ramaddr, 32'h100);
    check("c_instr_ramren", 32'(ramREN), 32'd1);
    cyc(); iREN = 1'b0; settle();
    check("ab_iwait", 32'(iwait), 32'd1);
    cyc(); settle();
    check("ab_idle_ramren", 32'(ramREN), 32'd0);
    check("ab_idle_iwait", 32'(iwait), 32'd1);

    // Read+write together: write wins
    cyc(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF; settle();
    cyc(); settle();
    check("w_ramwen", 32'(ramWEN), 32'd1);
    check("w_ramren", 32'(ramREN), 32'd0);
    check("w_ramstore", ramstore, 32'hDEADBEEF);
    check("w_ramaddr", ramaddr, 32'h200);
    cyc(); ramstate = ACCESS; ramload = 32'h0; settle();
    check("w_dwait", 32'(dwait), 32'd0);
    cyc(); dREN = 1'b0; dWEN = 1'b0; ramstate = FREE; settle();
    check("w_idle_ramwen", 32'(ramWEN), 32'd0);
    check("w_idle_ramstore", ramstore, 32'h0);

    // Watchdog: BUSY forever, FAULT after 4 granted cycles
    cyc(); dREN = 1'b1; daddr = 32'h300; ramstate = BUSY; settle();
    for (int i = 0; i < 4; i++) begin
      cyc(); settle();
      check($sformatf("to_g%0d_err", i), 32'(err), 32'd0);
      check($sformatf("to_g%0d_ramren", i), 32'(ramREN), 32'd1);
    end
    cyc(); settle();
    check("to_err", 32'(err), 32'd1);
    check("to_dwait", 32'(dwait), 32'd1);
    check("to_iwait", 32'(iwait), 32'd1);
    check("to_ramren", 32'(ramREN), 32'd0);
    cyc(); ramstate = ACCESS; settle();
    check("to_sticky_err", 32'(err), 32'd1);
    check("to_sticky_dwait", 32'(dwait), 32'd1);
    RST = 1'b1; ramstate = FREE; dREN = 1'b0;
    cyc(); settle();
    check("to_rst_err", 32'(err), 32'd0);
    RST = 1'b0;

    // Reset during DATA
    cyc(); dREN = 1'b1; daddr = 32'h400; ramstate = BUSY; settle();
    cyc(); settle();
    check("rd_ramren", 32'(ramREN), 32'd1);
    RST = 1'b1;
    cyc(); settle();
    check("rd_ramren_after", 32'(ramREN), 32'd0);
    check("rd_ramaddr_after", ramaddr, 32'h0);
    check("rd_dwait_after", 32'(dwait), 32'd1);
    check("rd_dload_after", dload, 32'h0);
    RST = 1'b0; dREN = 1'b0;

    // ERROR during INSTR
    cyc(); iREN = 1'b1; iaddr = 32'h500; ramstate = BUSY; settle();
    cyc(); ramstate = ERROR; settle();
    check("er_instr_err", 32'(err), 32'd0);
    check("er_instr_ramren", 32'(ramREN), 32'd1);
    cyc(); ramstate = FREE; settle();
    check("er_fault_err", 32'(err), 32'd1);
    check("er_fault_iwait", 32'(iwait), 32'd1);
    check("er_fault_ramren", 32'(ramREN), 32'd0);
    RST = 1'b1; iREN = 1'b0;
    cyc(); settle();
    check("er_rst_err", 32'(err), 32'd0);
    RST = 1'b0;

    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
